sa_cache_plru: RTL and testbench
================================

Name: sa_cache_plru

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache; one data word per line.
- Tree pseudo-LRU replacement is internal; no external way selector.
- Request/response handshake on the core side; eviction handshake on the memory side.
- Successor to the current fixed 4-way, write-through-less cache array; sits between the CPU load/store port and the memory model.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, line/word width; power of 2, >= 8.
- NUM_SETS, 32, number of sets; power of 2, >= 2.
- NUM_WAYS, 4, associativity; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  lookup hit.
- resp_rdata  out  DATA_W  read data on read hit, else 0.
- evict_valid  out  1  dirty victim pending.
- evict_ready  in  1  memory accepts victim.
- evict_addr  out  ADDR_W  victim line address, offset bits 0.
- evict_data  out  DATA_W  victim data.

Behaviour:
- Address decode: OFFSET_W = log2(DATA_W/8); index = addr[OFFSET_W +: log2(NUM_SETS)]; tag = remaining upper bits, width TAG_W = ADDR_W - SET_W - OFFSET_W.
- Per line storage: valid, dirty, tag, data. Per set: NUM_WAYS-1 PLRU bits.
- Reset clears all valid, dirty and PLRU bits, and returns the FSM to IDLE.
- Reset values: req_ready=1 (IDLE), all other outputs 0. Reset mid-operation aborts the request with no response.
- FSM states: IDLE, LOOKUP, EVICT, RESP.
- IDLE: req_ready=1. On handshake, register write/addr/wdata and go to LOOKUP. req_ready=0 in every other state.
- LOOKUP: compare the tag against all ways of the set.
  - Read hit: latch data, update PLRU, go to RESP.
  - Read miss: no allocation, no PLRU change; go to RESP with hit=0, rdata=0.
  - Write hit: write data, set dirty, update PLRU, go to RESP with hit=1.
  - Write miss, victim clean or invalid: install line (valid=1, dirty=1), update PLRU, go to RESP with hit=0.
  - Write miss, victim dirty: go to EVICT.
- Victim selection: lowest-index invalid way if any; otherwise the tree-PLRU victim.
- PLRU encoding: bit 0 means the victim lies in the lower half. On access, every node on the path is set to point away from the accessed way.
- EVICT: evict_valid=1 with addr/data held stable until evict_ready. On handshake, install the new line, update PLRU, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, with hit/rdata valid; then return to IDLE. resp_hit/resp_rdata return to 0 outside RESP.
- Latency:
  - Handshake at cycle 0 gives resp_valid at cycle 2 (no eviction).
  - With eviction: 2 + cycles spent in EVICT.
  - Maximum throughput: one request per 3 cycles.
- Multiple-way tag match cannot occur by construction; the lowest-index match wins if it ever does.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum;
  - log2-derived widths (OFFSET_W, SET_W, TAG_W);
  - a line struct {valid, dirty, tag, data}.
- One sub-module, plru_tree: purely combinational.
  - Inputs: set PLRU bits, accessed way.
  - Outputs: updated bits, victim way.
  - Parametrised by NUM_WAYS.

Test Plan (defaults; index = addr[6:2], tag = addr[31:7]):
1. Reset, read 0x0000_1000 -> resp_valid at cycle 2, hit=0, rdata=0, evict_valid never asserted.
2. Write 0x0000_1000 with 0xDEADBEEF, then read 0x0000_1000 -> write resp hit=0; read resp hit=1, rdata=0xDEADBEEF.
3. Eviction order in set 0:
   - Stimulus: write 0x000, 0x080, 0x100, 0x180 (data 0x11..0x44); read 0x000; write 0x200 with 0x55.
   - Required: the read hits with 0x11; evict_valid with evict_addr=0x100, evict_data=0x33 (way 2).
   - Follow-up: a read of 0x100 misses and a read of 0x200 returns 0x55.
4. Scenario 3 with evict_ready held low for 5 cycles -> evict_valid, evict_addr and evict_data stay stable, req_ready=0, no resp_valid; resp_valid comes 1 cycle after the evict handshake.
5. Reset asserted during EVICT -> all outputs 0 immediately, req_ready=1 after release, read of 0x000 misses.
6. Write 0x000 = 0xA, then write 0x000 = 0xB, then read -> second write hit=1 with no eviction; read returns 0xB.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared state encoding, geometry helpers and line layout for the set-associative PLRU cache.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT,
    ST_RESP
  } state_e;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_SETS = 32;
  localparam int unsigned DEF_NUM_WAYS = 4;

  function automatic int unsigned offset_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned set_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned data_w,
                                        input int unsigned num_sets);
    return addr_w - set_w(num_sets) - offset_w(data_w);
  endfunction

  localparam int unsigned OFFSET_W = offset_w(DEF_DATA_W);
  localparam int unsigned SET_W    = set_w(DEF_NUM_SETS);
  localparam int unsigned TAG_W    = tag_w(DEF_ADDR_W, DEF_DATA_W, DEF_NUM_SETS);

  // Line layout at the default geometry; the cache re-declares it at its own widths.
  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [TAG_W-1:0]      tag;
    logic [DEF_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim lookup and path update for an accessed way.
// Nodes are heap-ordered from the root; a node bit of 0 places the victim in the lower half.
module plru_tree #(
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-2:0]         bits_i,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way_i,
  output logic [NUM_WAYS-2:0]         upd_bits_o,
  output logic [$clog2(NUM_WAYS)-1:0] victim_o
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  logic [WAY_W-1:0] vic_node;
  logic [WAY_W-1:0] upd_node;
  logic [WAY_W-1:0] way_sh;
  logic             dir;

  always_comb begin
    vic_node = '0;
    victim_o = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      victim_o = WAY_W'({victim_o, bits_i[vic_node]});
      vic_node = WAY_W'({vic_node, 1'b1}) + WAY_W'(bits_i[vic_node]);
    end
  end

  // Every node on the accessed path is turned to point at the other half.
  always_comb begin
    upd_bits_o = bits_i;
    upd_node   = '0;
    way_sh     = access_way_i;
    dir        = 1'b0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir                  = way_sh[WAY_W-1];
      upd_bits_o[upd_node] = ~dir;
      upd_node             = WAY_W'({upd_node, 1'b1}) + WAY_W'(dir);
      way_sh               = way_sh << 1;
    end
  end

endmodule

// File: rtl/sa_cache_plru.sv
// N-way set-associative write-back, write-allocate cache with one word per line,
// tree-PLRU replacement and a held eviction handshake for dirty victims.
module sa_cache_plru
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_SETS = DEF_NUM_SETS,
  parameter int unsigned NUM_WAYS = DEF_NUM_WAYS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              evict_valid,
  input  logic              evict_ready,
  output logic [ADDR_W-1:0] evict_addr,
  output logic [DATA_W-1:0] evict_data
);
  localparam int unsigned OFF_W  = offset_w(DATA_W);
  localparam int unsigned IDX_W  = set_w(NUM_SETS);
  localparam int unsigned TG_W   = tag_w(ADDR_W, DATA_W, NUM_SETS);
  localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
  localparam int unsigned PLRU_W = NUM_WAYS - 1;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TG_W-1:0]   tag;
    logic [DATA_W-1:0] data;
  } way_line_t;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              evict_valid_q, evict_valid_d;
  logic [ADDR_W-1:0] evict_addr_q, evict_addr_d;
  logic [DATA_W-1:0] evict_data_q, evict_data_d;

  logic              write_q;
  logic [TG_W-1:0]   tag_q;
  logic [IDX_W-1:0]  set_q;
  logic [DATA_W-1:0] wdata_q;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [TG_W-1:0]     tags_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
  logic [PLRU_W-1:0]   plru_q  [NUM_SETS];

  way_line_t         lines [NUM_WAYS];
  way_line_t         victim;
  logic              hit, has_inv;
  logic [WAY_W-1:0]  hit_way, inv_way, victim_way, access_way, plru_victim;
  logic [PLRU_W-1:0] plru_upd;
  logic [ADDR_W-1:0] victim_addr;
  logic              wr_en, plru_we;
  logic [WAY_W-1:0]  wr_way;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr;

  // Addressed set; scanning downward lets the lowest-index match / invalid way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      lines[w].valid = valid_q[set_q][w];
      lines[w].dirty = dirty_q[set_q][w];
      lines[w].tag   = tags_q[set_q][w];
      lines[w].data  = data_q[set_q][w];
      if (lines[w].valid && (lines[w].tag == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!lines[w].valid) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim_way  = has_inv ? inv_way : plru_victim;
  assign access_way  = hit ? hit_way : victim_way;
  assign victim      = lines[victim_way];
  assign victim_addr = ADDR_W'({victim.tag, set_q}) << OFF_W;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .bits_i      (plru_q[set_q]),
    .access_way_i(access_way),
    .upd_bits_o  (plru_upd),
    .victim_o    (plru_victim)
  );

  always_comb begin
    state_d       = state_q;
    resp_hit_d    = 1'b0;
    resp_rdata_d  = '0;
    evict_valid_d = 1'b0;
    evict_addr_d  = '0;
    evict_data_d  = '0;
    wr_en         = 1'b0;
    wr_way        = victim_way;
    plru_we       = 1'b0;
    unique case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        state_d = ST_RESP;
        if (hit) begin
          resp_hit_d = 1'b1;
          plru_we    = 1'b1;
          if (write_q) begin
            wr_en  = 1'b1;
            wr_way = hit_way;
          end else begin
            resp_rdata_d = lines[hit_way].data;
          end
        end else if (write_q) begin
          if (victim.valid && victim.dirty) begin
            state_d       = ST_EVICT;
            evict_valid_d = 1'b1;
            evict_addr_d  = victim_addr;
            evict_data_d  = victim.data;
          end else begin
            wr_en   = 1'b1;
            plru_we = 1'b1;
          end
        end
      end
      ST_EVICT: begin
        if (evict_ready) begin
          state_d = ST_RESP;
          wr_en   = 1'b1;
          plru_we = 1'b1;
        end else begin
          evict_valid_d = 1'b1;
          evict_addr_d  = evict_addr_q;
          evict_data_d  = evict_data_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_rdata_q  <= '0;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      evict_data_q  <= '0;
      write_q       <= 1'b0;
      tag_q         <= '0;
      set_q         <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_rdata_q  <= resp_rdata_d;
      evict_valid_q <= evict_valid_d;
      evict_addr_q  <= evict_addr_d;
      evict_data_q  <= evict_data_d;
      if ((state_q == ST_IDLE) && req_valid) begin
        write_q <= req_write;
        tag_q   <= req_addr[ADDR_W-1 -: TG_W];
        set_q   <= req_addr[OFF_W +: IDX_W];
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (wr_en) begin
        valid_q[set_q][wr_way] <= 1'b1;
        dirty_q[set_q][wr_way] <= 1'b1;
      end
      if (plru_we) plru_q[set_q] <= plru_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags_q[set_q][wr_way] <= tag_q;
      data_q[set_q][wr_way] <= wdata_q;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_rdata  = resp_rdata_q;
  assign evict_valid = evict_valid_q;
  assign evict_addr  = evict_addr_q;
  assign evict_data  = evict_data_q;

endmodule

// File: tb/tb_sa_cache_plru.sv
// Directed and randomized bench for sa_cache_plru against a per-set behavioural cache model.
module tb_sa_cache_plru;
  localparam int NSETS = 32;
  localparam int NWAYS = 4;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        evict_valid, evict_ready;
  logic [31:0] evict_addr, evict_data;

  int checks, errors;
  logic        last_hit;
  logic [31:0] last_rdata, last_ea, last_ed;

  sa_cache_plru dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per-way line contents plus a 1-based heap of "victim is in the upper half" flags.
  bit          m_valid [NSETS][NWAYS];
  bit          m_dirty [NSETS][NWAYS];
  logic [24:0] m_tag   [NSETS][NWAYS];
  logic [31:0] m_data  [NSETS][NWAYS];
  bit          m_upper [NSETS][NWAYS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_upper[s][w] = 1'b0;
      end
  endtask

  function automatic int m_victim(input int s);
    int n = 1, lo = 0, size = NWAYS;
    while (size > 1) begin
      size = size / 2;
      if (m_upper[s][n]) begin lo += size; n = 2 * n + 1; end
      else n = 2 * n;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int n = 1, lo = 0, size = NWAYS;
    while (size > 1) begin
      size = size / 2;
      if (w < lo + size) begin m_upper[s][n] = 1'b1; n = 2 * n; end
      else begin m_upper[s][n] = 1'b0; lo += size; n = 2 * n + 1; end
    end
  endtask

  task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                              output bit eh, output logic [31:0] er, output bit ee,
                              output logic [31:0] ea, output logic [31:0] ed);
    int s, w;
    logic [24:0] t;
    s = int'(addr[6:2]);
    t = addr[31:7];
    eh = 1'b0; er = '0; ee = 1'b0; ea = '0; ed = '0;
    w = -1;
    for (int i = 0; i < NWAYS; i++) if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
    if (w >= 0) begin
      eh = 1'b1;
      if (wr) begin m_data[s][w] = wd; m_dirty[s][w] = 1'b1; end
      else er = m_data[s][w];
      m_touch(s, w);
    end else if (wr) begin
      for (int i = 0; i < NWAYS; i++) if (w < 0 && !m_valid[s][i]) w = i;
      if (w < 0) w = m_victim(s);
      if (m_valid[s][w] && m_dirty[s][w]) begin
        ee = 1'b1;
        ea = {m_tag[s][w], 5'(s), 2'b00};
        ed = m_data[s][w];
      end
      m_valid[s][w] = 1'b1; m_dirty[s][w] = 1'b1; m_tag[s][w] = t; m_data[s][w] = wd;
      m_touch(s, w);
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int stall);
    bit eh, ee, seen_ev, done;
    logic [31:0] er, ea, ed;
    int t, ecyc;
    model_access(wr, addr, wd, eh, er, ee, ea, ed);
    last_ea = '0; last_ed = '0;
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    t = 1; ecyc = 0; seen_ev = 1'b0; done = 1'b0;
    while (!done && t < 64) begin
      if (resp_valid) begin
        check("resp_hit", resp_hit, eh);
        check("resp_rdata", resp_rdata, er);
        check("resp_latency", t, 2 + ecyc);
        check("evict_seen", seen_ev, ee);
        check("evict_cycles", ecyc, ee ? stall + 1 : 0);
        last_hit = resp_hit; last_rdata = resp_rdata;
        done = 1'b1;
      end else begin
        check("req_ready_busy", req_ready, 1'b0);
        check("resp_idle_zero", {resp_hit, resp_rdata}, 33'd0);
        if (evict_valid) begin
          check("evict_addr", evict_addr, ea);
          check("evict_data", evict_data, ed);
          last_ea = evict_addr; last_ed = evict_data;
          seen_ev = 1'b1;
          ecyc++;
          evict_ready = (ecyc > stall);
        end
        @(posedge clk); #1;
        evict_ready = 1'b0;
        t++;
      end
    end
    check("resp_timeout", done, 1'b1);
    @(posedge clk); #1;
    check("resp_pulse_end", resp_valid, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = 1'b0; evict_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_outputs_zero", {resp_valid, resp_hit, resp_rdata, evict_valid, evict_addr, evict_data},
          99'd0);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("post_rst_ready", req_ready, 1'b1);
  endtask

  task automatic fill_set0(input int stall);
    do_req(1'b1, 32'h000, 32'h11, stall);
    do_req(1'b1, 32'h080, 32'h22, stall);
    do_req(1'b1, 32'h100, 32'h33, stall);
    do_req(1'b1, 32'h180, 32'h44, stall);
    do_req(1'b0, 32'h000, 32'h0, stall);
    check("t3_read_hit", {last_hit, last_rdata}, {1'b1, 32'h11});
  endtask

  initial begin
    bit seen;
    checks = 0; errors = 0;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    evict_ready = 1'b0;
    #2;
    apply_reset();

    // 1-2: cold read miss, write-allocate, read back
    do_req(1'b0, 32'h1000, 32'h0, 0);
    check("t1_miss", {last_hit, last_rdata}, 33'd0);
    do_req(1'b1, 32'h1000, 32'hDEADBEEF, 0);
    check("t2_write_miss", last_hit, 1'b0);
    do_req(1'b0, 32'h1000, 32'h0, 0);
    check("t2_read_hit", {last_hit, last_rdata}, {1'b1, 32'hDEADBEEF});

    // 3: PLRU eviction order in set 0
    apply_reset();
    fill_set0(0);
    do_req(1'b1, 32'h200, 32'h55, 0);
    check("t3_evict", {last_ea, last_ed}, {32'h100, 32'h33});
    do_req(1'b0, 32'h100, 32'h0, 0);
    check("t3_evicted_miss", last_hit, 1'b0);
    do_req(1'b0, 32'h200, 32'h0, 0);
    check("t3_new_line", {last_hit, last_rdata}, {1'b1, 32'h55});

    // 4: eviction back-pressure
    apply_reset();
    fill_set0(0);
    do_req(1'b1, 32'h200, 32'h55, 5);
    check("t4_evict", {last_ea, last_ed}, {32'h100, 32'h33});

    // 5: reset while an eviction is pending
    apply_reset();
    fill_set0(0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (evict_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("t5_evict_pending", {seen, evict_addr}, {1'b1, 32'h100});
    reset = 1'b1;
    #1;
    check("t5_rst_outputs", {resp_valid, resp_hit, resp_rdata, evict_valid, evict_addr, evict_data},
          99'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("t5_ready_after", req_ready, 1'b1);
    do_req(1'b0, 32'h000, 32'h0, 0);
    check("t5_read_miss", last_hit, 1'b0);

    // 6: overwrite of a resident line
    apply_reset();
    do_req(1'b1, 32'h000, 32'hA, 0);
    do_req(1'b1, 32'h000, 32'hB, 0);
    check("t6_write_hit", last_hit, 1'b1);
    do_req(1'b0, 32'h000, 32'h0, 0);
    check("t6_read", {last_hit, last_rdata}, {1'b1, 32'hB});

    // Random traffic over a few crowded sets
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = {25'($urandom_range(0, 7)), 5'($urandom_range(0, 2)), 2'($urandom)};
      do_req(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
